// File: rtl/pong_pkg.sv
// Shared pong constants, mode encodings and CPU-tracker state types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  // Screen geometry in pixels
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int TOP_MARGIN    = 25;
  localparam int BALL_SIZE     = 8;
  localparam int PADDLE_HEIGHT = 72;

  // Paddle-top offset range below the score bar
  localparam int Y_MAX = SCREEN_HEIGHT - TOP_MARGIN - PADDLE_HEIGHT;  // 383
  localparam int Y_CTR = Y_MAX / 2;                                   // 191

  localparam logic [9:0]        Y_MAX_V = 10'(Y_MAX);
  localparam logic [9:0]        Y_CTR_V = 10'(Y_CTR);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic signed [10:0] Y_CTR_S = 11'(Y_CTR);

  // Offsets used to compare ball centre with paddle centre in screen space
  localparam logic signed [10:0] BALL_HALF_S  = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] PADDLE_OFF_S = 11'(TOP_MARGIN + PADDLE_HEIGHT / 2);

  // main_state encodings; anything else is a frozen state
  localparam logic [1:0] MS_MENU = 2'd0;
  localparam logic [1:0] MS_PLAY = 2'd1;

  // CPU tracker states
  typedef enum logic [1:0] {
    AI_IDLE   = 2'd0,
    AI_REACT  = 2'd1,
    AI_TRACK  = 2'd2,
    AI_RETURN = 2'd3
  } ai_state_t;

  // Step direction in screen terms: UP lowers y, DN raises y
  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } step_dir_t;

  // Button pair to direction; both or neither pressed means hold
  function automatic step_dir_t btn_dir(input logic up, input logic dn);
    step_dir_t d;
    d = DIR_HOLD;
    if (up && !dn) d = DIR_UP;
    else if (dn && !up) d = DIR_DN;
    return d;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Bundle of frame strobe, game mode, buttons, ball positions and paddle outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle strobes.
interface paddle_ctrl_if;
  logic       refresh_tick;
  logic [1:0] game_mode;
  logic [1:0] main_state;
  logic       btn_up1;
  logic       btn_dn1;
  logic       btn_up2;
  logic       btn_dn2;
  logic       cpu_enable;
  logic [9:0] ball_x_0;
  logic [9:0] ball_y_0;
  logic [9:0] ball_x_1;
  logic [9:0] ball_y_1;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;

  // Game side: drives controls and ball positions, consumes paddle positions
  modport master (
    output refresh_tick, game_mode, main_state,
    output btn_up1, btn_dn1, btn_up2, btn_dn2, cpu_enable,
    output ball_x_0, ball_y_0, ball_x_1, ball_y_1,
    input  paddle1_y, paddle2_y
  );

  // Paddle controller side
  modport slave (
    input  refresh_tick, game_mode, main_state,
    input  btn_up1, btn_dn1, btn_up2, btn_dn2, cpu_enable,
    input  ball_x_0, ball_y_0, ball_x_1, ball_y_1,
    output paddle1_y, paddle2_y
  );
endinterface

// File: rtl/paddle_step.sv
// Saturating paddle stepper: moves y by step in dir, clamped to 0..Y_MAX.
// Latency: combinational.
// Backpressure: none.
module paddle_step
  import pong_pkg::*;
(
  input  logic [9:0] y_i,
  input  step_dir_t  dir_i,
  input  logic [9:0] step_i,
  output logic [9:0] y_o
);

  logic signed [10:0] y_s;
  logic signed [10:0] step_s;
  logic signed [10:0] sum_s;

  // Signed intermediate so an upward step below zero clamps instead of wrapping
  always_comb begin
    y_s    = signed'({1'b0, y_i});
    step_s = signed'({1'b0, step_i});
    sum_s  = y_s;
    y_o    = y_i;
    case (dir_i)
      DIR_UP:  sum_s = y_s - step_s;
      DIR_DN:  sum_s = y_s + step_s;
      default: sum_s = y_s;
    endcase
    if (sum_s < 11'sd0)        y_o = 10'd0;
    else if (sum_s > Y_MAX_S)  y_o = Y_MAX_V;
    else                       y_o = sum_s[9:0];
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: human paddle 1, human or CPU-tracked paddle 2.
// Latency: positions update on the clk edge after a sampled refresh_tick; MENU recentres on any edge.
// Backpressure: none; inputs are sampled only on tick cycles.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_SPEED   = 4,
  parameter int AI_SPEED       = 2,
  parameter int AI_DEADBAND    = 4,   // must be >= AI_SPEED so tracking cannot oscillate
  parameter int AI_REACT_TICKS = 3    // >= 1
)
(
  input  logic          clk,
  input  logic          reset,
  paddle_ctrl_if.slave  pif
);

  localparam logic signed [10:0] AI_SPEED_S = 11'(AI_SPEED);
  localparam logic signed [10:0] DEADBAND_S = 11'(AI_DEADBAND);
  localparam logic [3:0]         REACT_LD   = 4'(AI_REACT_TICKS);

  logic [9:0] p1_q, p1_d;
  logic [9:0] p2_q, p2_d;
  logic [9:0] prev_x_q, prev_x_d;
  logic [3:0] cnt_q, cnt_d;
  ai_state_t  state_q, state_d;

  logic               play_tick;
  logic               sel_ball1;
  logic [9:0]         tgt_x;
  logic [9:0]         tgt_y;
  logic               appr;
  logic signed [10:0] err_s;
  logic signed [10:0] err_abs_s;
  logic signed [10:0] ctr_diff_s;
  logic signed [10:0] ctr_abs_s;

  step_dir_t  ai_dir;
  logic       ai_snap;
  step_dir_t  p2_dir;
  logic [9:0] p2_step;
  logic [9:0] p1_next;
  logic [9:0] p2_next;

  assign play_tick = (pif.main_state == MS_PLAY) && pif.refresh_tick;

  // Target ball, approach flag and centre errors seen by the tracker
  always_comb begin
    sel_ball1  = (pif.game_mode != 2'd0) && (pif.ball_x_1 > pif.ball_x_0);
    tgt_x      = sel_ball1 ? pif.ball_x_1 : pif.ball_x_0;
    tgt_y      = sel_ball1 ? pif.ball_y_1 : pif.ball_y_0;
    appr       = tgt_x > prev_x_q;
    err_s      = (signed'({1'b0, tgt_y}) + BALL_HALF_S)
               - (signed'({1'b0, p2_q}) + PADDLE_OFF_S);
    err_abs_s  = (err_s < 11'sd0) ? -err_s : err_s;
    ctr_diff_s = signed'({1'b0, p2_q}) - Y_CTR_S;
    ctr_abs_s  = (ctr_diff_s < 11'sd0) ? -ctr_diff_s : ctr_diff_s;
  end

  // CPU tracker next state and requested paddle-2 motion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ai_dir  = DIR_HOLD;
    ai_snap = 1'b0;
    if (pif.main_state != MS_PLAY) begin
      state_d = AI_IDLE;
      cnt_d   = 4'd0;
    end else if (pif.refresh_tick) begin
      if (!pif.cpu_enable) begin
        state_d = AI_IDLE;
      end else begin
        case (state_q)
          AI_IDLE: begin
            if (appr) begin
              state_d = AI_REACT;
              cnt_d   = REACT_LD;
            end
          end
          AI_REACT: begin
            if (!appr)               state_d = AI_RETURN;
            else if (cnt_q == 4'd1)  state_d = AI_TRACK;
            else                     cnt_d   = cnt_q - 4'd1;
          end
          AI_TRACK: begin
            if (!appr)                       state_d = AI_RETURN;
            else if (err_abs_s > DEADBAND_S) ai_dir  = (err_s < 11'sd0) ? DIR_UP : DIR_DN;
          end
          AI_RETURN: begin
            if (appr) begin
              state_d = AI_REACT;
              cnt_d   = REACT_LD;
            end else if (ctr_abs_s <= AI_SPEED_S) begin
              ai_snap = 1'b1;
              state_d = AI_IDLE;
            end else begin
              ai_dir  = (ctr_diff_s > 11'sd0) ? DIR_UP : DIR_DN;
            end
          end
          default: state_d = AI_IDLE;
        endcase
      end
    end
  end

  // Paddle 2 follows either its buttons or the tracker
  always_comb begin
    p2_dir  = btn_dir(pif.btn_up2, pif.btn_dn2);
    p2_step = 10'(PADDLE_SPEED);
    if (pif.cpu_enable) begin
      p2_dir  = ai_dir;
      p2_step = 10'(AI_SPEED);
    end
  end

  paddle_step u_step1 (
    .y_i    (p1_q),
    .dir_i  (btn_dir(pif.btn_up1, pif.btn_dn1)),
    .step_i (10'(PADDLE_SPEED)),
    .y_o    (p1_next)
  );

  paddle_step u_step2 (
    .y_i    (p2_q),
    .dir_i  (p2_dir),
    .step_i (p2_step),
    .y_o    (p2_next)
  );

  // Position and prev_x next values; MENU recentres without waiting for a tick
  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    prev_x_d = prev_x_q;
    if (pif.main_state == MS_MENU) begin
      p1_d     = Y_CTR_V;
      p2_d     = Y_CTR_V;
      prev_x_d = 10'd0;
    end else if (play_tick) begin
      p1_d     = p1_next;
      p2_d     = (pif.cpu_enable && ai_snap) ? Y_CTR_V : p2_next;
      prev_x_d = tgt_x;
    end
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q     <= Y_CTR_V;
      p2_q     <= Y_CTR_V;
      prev_x_q <= 10'd0;
      cnt_q    <= 4'd0;
      state_q  <= AI_IDLE;
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      prev_x_q <= prev_x_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign pif.paddle1_y = p1_q;
  assign pif.paddle2_y = p2_q;

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Produces `paddle1_y`/`paddle2_y` for the pong datapath, the input side of the ball engine's paddle-collision check. Paddle 1 is always human-driven from buttons; paddle 2 is human-driven or, with `cpu_enable`, steered by a CPU tracker FSM. The CPU tracker watches `ball_x_*`/`ball_y_*` and adds a reaction delay. Positions are paddle-top offsets below `TOP_MARGIN`, which is the convention the collision logic expects.

## Interface
- `PADDLE_HEIGHT`, 72: paddle length in pixels; collision window is `paddle_y+TOP_MARGIN .. +PADDLE_HEIGHT`.
- `TOP_MARGIN`, 25: score-bar height.
- `SCREEN_HEIGHT`, 480: visible lines.
- `BALL_SIZE`, 8: ball square size.
- `PADDLE_SPEED`, 4: human step per tick.
- `AI_SPEED`, 2: CPU step per tick.
- `AI_DEADBAND`, 4: CPU stops when |error| ≤ this. Must satisfy `AI_DEADBAND >= AI_SPEED`.
- `AI_REACT_TICKS`, 3: reaction delay load value, ≥1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `refresh_tick` in 1: one-cycle frame strobe.
- `game_mode` in 2: 0 = one ball, 1 = two balls.
- `main_state` in 2: 0 = MENU, 1 = PLAY, 2/3 = frozen.
- `btn_up1`, `btn_dn1`, `btn_up2`, `btn_dn2` in 1 each: debounced level inputs.
- `cpu_enable` in 1: paddle 2 under CPU control.
- `ball_x_0`, `ball_y_0`, `ball_x_1`, `ball_y_1` in 10 each: ball top-left positions, screen coordinates.
- `paddle1_y`, `paddle2_y` out 10 each: registered paddle offsets.

## Operation
- `Y_MAX = SCREEN_HEIGHT - TOP_MARGIN - PADDLE_HEIGHT` (383). `Y_CTR = Y_MAX/2` (191).
- All arithmetic uses 11-bit signed intermediates. Results clamp to 0..Y_MAX and never wrap.
- MENU: on every clk edge, both paddles are forced to Y_CTR, the FSM goes to IDLE, and `prev_x` is cleared.
- Frozen states (2/3): positions hold, the FSM is forced to IDLE, and the react counter is cleared.
- PLAY: updates occur only on cycles with `refresh_tick`=1.
- Human step:
  - up only: `y -= PADDLE_SPEED`, saturating at 0.
  - down only: `y += PADDLE_SPEED`, saturating at Y_MAX.
  - both or neither: hold.
- Paddle 2 is human when `cpu_enable`=0. On the first tick with `cpu_enable`=0, the FSM goes to IDLE.
- CPU target ball:
  - `game_mode`=0: ball 0.
  - Otherwise: the ball with larger x, i.e. nearer the right paddle; a tie selects ball 0.
- CPU error: `err = (ball_y + BALL_SIZE/2) - (paddle2_y + TOP_MARGIN + PADDLE_HEIGHT/2)`.
- Approach flag: `appr = target_x > prev_x`. `prev_x` is latched to `target_x` every PLAY tick.
- The first tick after reset sees `prev_x`=0, so any x>0 reads as approaching.
- FSM states and transitions, evaluated on PLAY ticks with `cpu_enable`=1:
  - IDLE: if `appr`, go to REACT and load counter = AI_REACT_TICKS. No move.
  - REACT: no move. If `!appr`, go to RETURN. Else if counter==1, go to TRACK. Else decrement the counter.
  - TRACK: if `!appr`, go to RETURN with no move. Else if |err| > AI_DEADBAND, step AI_SPEED toward the sign of `err`, clamped. Else hold.
  - RETURN: if `appr`, go to REACT (reload the counter). Else if |y − Y_CTR| ≤ AI_SPEED, set y = Y_CTR and go to IDLE. Else step AI_SPEED toward Y_CTR.
- A target switch between balls in two-ball mode needs no special handling: `prev_x` compares across the switch, and the glitch is tolerated.

## Timing
- Reset values:
  - `paddle1_y` = `paddle2_y` = 191.
  - FSM = IDLE, counter = 0, `prev_x` = 0.
- Outputs are valid on the clk edge after the sampled `refresh_tick` (1-cycle latency). They are stable between ticks.
- Reset has priority over everything. Reset mid-track returns to the reset values on that edge.
- MENU overrides `refresh_tick`.
- CPU first move: the (AI_REACT_TICKS+1)th tick after the detection tick. The detection tick is the IDLE→REACT transition.
- Inputs are sampled only on the tick cycle. Button pulses between ticks are ignored.

## Structure
- Shared package `pong_pkg` holds:
  - SCREEN_WIDTH/HEIGHT, TOP_MARGIN, BALL_SIZE, PADDLE_HEIGHT and derived Y_MAX/Y_CTR.
  - The `main_state` encodings (MENU/PLAY).
  - The CPU FSM state enum (IDLE/REACT/TRACK/RETURN).
- Sub-module `paddle_step`: combinational saturating stepper (y, dir, step → y_next), instantiated for each paddle.
- The FSM, target select and `prev_x` register live in the top module.

## Test plan
- Reset, then PLAY with no buttons → both outputs 191 indefinitely. Pulse reset mid-motion → 191 on the next edge.
- `btn_dn1` held for 60 ticks → 191+4k each tick, reaching 383 at tick 48 and holding. Then `btn_up1`+`btn_dn1` together → stays 383.
- Frozen and MENU states:
  - `main_state`=2 with `btn_up2` held → `paddle2_y` unchanged.
  - Switch to `main_state`=0 → both outputs 191 on the next clk, with no tick needed.
- CPU tracking: `cpu_enable`=1, `game_mode`=0, `ball_y_0`=400, `ball_x_0` rising by 2 per tick from 100.
  - `paddle2_y` holds 191 through the detection tick and 3 REACT ticks.
  - It then steps +2 per tick and settles at 339 (err=4).
- CPU return: continue from the tracking scenario with `ball_x_0` falling → RETURN. Paddle steps −2 per tick to 191, then IDLE, then holds.
- Two-ball target select: `game_mode`=1, ball 0 at (500,100), ball 1 at (550,300), both x rising → paddle tracks toward ball 1 and settles at 239 (ball centre 304, paddle centre 300, err=4).
